// File: rtl/divider_r4_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : divider_r4_ctrl                                            |
// | Description : Issue/collect wrapper for divider_r4. Accepts divide       |
// |               requests, holds operands stable while the divider runs,    |
// |               pulses start, captures results on done and queues them in  |
// |               a 2-entry response FIFO. Divide-by-zero bypasses divider.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module divider_r4_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [DATA_WIDTH-1:0] req_in1,
   input  logic [DATA_WIDTH-1:0] req_in2,
   input  logic                  req_sign,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic                  div_start,
   output logic [DATA_WIDTH-1:0] div_in1,
   output logic [DATA_WIDTH-1:0] div_in2,
   output logic                  div_sign,
   input  logic [DATA_WIDTH-1:0] div_quot,
   input  logic [DATA_WIDTH-1:0] div_rem,
   input  logic                  div_done,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_quot,
   output logic [DATA_WIDTH-1:0] resp_rem,
   output logic                  resp_dbz,
   output logic [TAG_WIDTH-1:0]  resp_tag
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_CLR  = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] quot;
      logic [DATA_WIDTH-1:0] rem;
      logic                  dbz;
      logic [TAG_WIDTH-1:0]  tag;
   } entry_t;

   localparam logic [1:0] c_fifo_full = 2'd2;

   state_t                state_q,   state_d;
   logic [DATA_WIDTH-1:0] op_in1_q,  op_in1_d;
   logic [DATA_WIDTH-1:0] op_in2_q,  op_in2_d;
   logic                  op_sign_q, op_sign_d;
   logic [TAG_WIDTH-1:0]  op_tag_q,  op_tag_d;

   entry_t                fifo_q [2];
   entry_t                fifo_d [2];
   logic                  wr_ptr_q, wr_ptr_d;
   logic                  rd_ptr_q, rd_ptr_d;
   logic [1:0]            count_q,  count_d;

   logic                  w_accept;
   logic                  w_fifo_wr;
   logic                  w_fifo_pop;
   entry_t                w_wr_entry;
   entry_t                w_head;

   assign req_ready  = (state_q == S_IDLE) && (count_q != c_fifo_full);
   assign w_accept   = req_valid && req_ready;
   assign resp_valid = (count_q != 2'd0);
   assign w_fifo_pop = resp_valid && resp_ready;

   // Operands go to the divider straight from the holding registers so they
   // stay put until the result is captured (the divider sign-corrects late).
   assign div_in1  = op_in1_q;
   assign div_in2  = op_in2_q;
   assign div_sign = op_sign_q;

   // Next-state, operand latching, start pulse and FIFO write selection.
   always_comb begin
      state_d    = state_q;
      op_in1_d   = op_in1_q;
      op_in2_d   = op_in2_q;
      op_sign_d  = op_sign_q;
      op_tag_d   = op_tag_q;
      div_start  = 1'b0;
      w_fifo_wr  = 1'b0;
      w_wr_entry = '0;
      case (state_q)
         S_IDLE: begin
            if (w_accept) begin
               if (req_in2 == '0) begin
                  // Divide-by-zero answers immediately without the divider.
                  w_fifo_wr       = 1'b1;
                  w_wr_entry.quot = '1;
                  w_wr_entry.rem  = req_in1;
                  w_wr_entry.dbz  = 1'b1;
                  w_wr_entry.tag  = req_tag;
               end else begin
                  op_in1_d  = req_in1;
                  op_in2_d  = req_in2;
                  op_sign_d = req_sign;
                  op_tag_d  = req_tag;
                  state_d   = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            div_start = 1'b1;
            state_d   = S_WAIT_CLR;
         end
         S_WAIT_CLR: begin
            // done may still be high from the previous op; wait for it to drop.
            if (!div_done) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            if (div_done) begin
               w_fifo_wr       = 1'b1;
               w_wr_entry.quot = div_quot;
               w_wr_entry.rem  = div_rem;
               w_wr_entry.dbz  = 1'b0;
               w_wr_entry.tag  = op_tag_q;
               state_d         = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Response FIFO pointer, occupancy and storage update.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (w_fifo_wr) begin
         fifo_d[wr_ptr_q] = w_wr_entry;
         wr_ptr_d         = ~wr_ptr_q;
      end
      if (w_fifo_pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({w_fifo_wr, w_fifo_pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Head entry is presented only while the FIFO holds something.
   always_comb begin
      w_head    = fifo_q[rd_ptr_q];
      resp_quot = resp_valid ? w_head.quot : '0;
      resp_rem  = resp_valid ? w_head.rem  : '0;
      resp_dbz  = resp_valid ? w_head.dbz  : 1'b0;
      resp_tag  = resp_valid ? w_head.tag  : '0;
   end

   // Control and operand registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         op_in1_q  <= '0;
         op_in2_q  <= '0;
         op_sign_q <= 1'b0;
         op_tag_q  <= '0;
      end else begin
         state_q   <= state_d;
         op_in1_q  <= op_in1_d;
         op_in2_q  <= op_in2_d;
         op_sign_q <= op_sign_d;
         op_tag_q  <= op_tag_d;
      end
   end

   // Response FIFO registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fifo_q[0] <= '0;
         fifo_q[1] <= '0;
         wr_ptr_q  <= 1'b0;
         rd_ptr_q  <= 1'b0;
         count_q   <= 2'd0;
      end else begin
         fifo_q    <= fifo_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_divider_r4_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_divider_r4_ctrl                                         |
// | Description : Self-checking bench for divider_r4_ctrl with a behavioural |
// |               stand-in for divider_r4 (level done, stale-high until it   |
// |               starts iterating, late sign correction from live inputs).  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_divider_r4_ctrl;
   localparam int W  = 32;
   localparam int TW = 4;

   logic          clk, rst_n;
   logic          req_valid, req_ready, req_sign;
   logic [W-1:0]  req_in1, req_in2;
   logic [TW-1:0] req_tag;
   logic          div_start, div_sign, div_done;
   logic [W-1:0]  div_in1, div_in2, div_quot, div_rem;
   logic          resp_valid, resp_ready, resp_dbz;
   logic [W-1:0]  resp_quot, resp_rem;
   logic [TW-1:0] resp_tag;

   int n_cmp = 0;
   int n_fail = 0;
   int cyc = 0;
   int start_cnt = 0;

   logic [1:0] dv_phase;
   int         dv_cnt;

   divider_r4_ctrl #(.DATA_WIDTH(W), .TAG_WIDTH(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_in1(req_in1), .req_in2(req_in2),
      .req_sign(req_sign), .req_tag(req_tag),
      .div_start(div_start), .div_in1(div_in1), .div_in2(div_in2), .div_sign(div_sign),
      .div_quot(div_quot), .div_rem(div_rem), .div_done(div_done),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_quot(resp_quot),
      .resp_rem(resp_rem), .resp_dbz(resp_dbz), .resp_tag(resp_tag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (rst_n && div_start) start_cnt <= start_cnt + 1;

   // Reference result: truncating division, remainder takes the dividend's sign.
   function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
      longint       sa, sb, q, r;
      logic [W-1:0] uq, ur;
      if (b == '0) return {{W{1'b1}}, a};
      if (!s) begin
         uq = a / b;
         ur = a % b;
         return {uq, ur};
      end
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {q[W-1:0], r[W-1:0]};
   endfunction

   // Divider stand-in: start seen, one load cycle with done still stale, then
   // iterate; done rises 16 edges after the start edge, result from live inputs.
   always @(posedge clk) begin
      if (!rst_n) begin
         dv_phase <= 2'd0; dv_cnt <= 0; div_done <= 1'b0; div_quot <= '0; div_rem <= '0;
      end else begin
         case (dv_phase)
            2'd0: if (div_start) dv_phase <= 2'd1;
            2'd1: begin dv_phase <= 2'd2; div_done <= 1'b0; dv_cnt <= W/2 - 1; end
            default: begin
               if (dv_cnt <= 1) begin
                  dv_phase <= 2'd0;
                  div_done <= 1'b1;
                  {div_quot, div_rem} <= ref_div(div_in1, div_in2, div_sign);
               end else begin
                  dv_cnt <= dv_cnt - 1;
               end
            end
         endcase
      end
   end

   // Drive a request from a negedge; returns at the negedge after acceptance.
   // acc = number of edges elapsed before the accepting edge.
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [TW-1:0] t, output int acc);
      int n = 0;
      req_in1 = a; req_in2 = b; req_sign = s; req_tag = t; req_valid = 1'b1;
      while (!req_ready && n < 200) begin @(negedge clk); n++; end
      if (!req_ready) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: req_ready got %b want 1", req_ready);
         acc = -1000;
         req_valid = 1'b0;
         return;
      end
      acc = cyc;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   // Wait (from a negedge) for resp_valid; returns the edge count when seen.
   task automatic wait_resp(output int at);
      int n = 0;
      while (!resp_valid && n < 100) begin @(negedge clk); n++; end
      if (!resp_valid) begin
         n_cmp++; n_fail++;
         $display("FAIL resp_timeout: resp_valid got %b want 1", resp_valid);
         at = -1;
      end else begin
         at = cyc;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
      n_cmp++; if (div_start !== 1'b0) begin n_fail++; $display("FAIL rst_div_start: got %b want 0", div_start); end
      n_cmp++; if ({div_in1, div_in2, div_sign} !== '0) begin n_fail++; $display("FAIL rst_div_ops: got %h %h %b want 0", div_in1, div_in2, div_sign); end
      n_cmp++; if ({resp_quot, resp_rem, resp_dbz, resp_tag} !== '0) begin n_fail++; $display("FAIL rst_resp_data: got %h %h %b %h want 0", resp_quot, resp_rem, resp_dbz, resp_tag); end
   endtask

   task automatic test_unsigned();
      int acc, at, s0, n, bad;
      resp_ready = 1'b1; s0 = start_cnt; bad = 0; n = 0;
      send(32'd100, 32'd7, 1'b0, 4'd3, acc);
      while (!resp_valid && n < 100) begin
         if (div_in1 !== 32'd100) bad++;
         @(negedge clk); n++;
      end
      wait_resp(at);
      n_cmp++; if (at - acc != 19) begin n_fail++; $display("FAIL u_latency: got %0d want 19", at - acc); end
      n_cmp++; if ({resp_quot, resp_rem, resp_dbz, resp_tag} !== {32'd14, 32'd2, 1'b0, 4'd3}) begin
         n_fail++; $display("FAIL u_result: got %h %h %b %h want e 2 0 3", resp_quot, resp_rem, resp_dbz, resp_tag); end
      n_cmp++; if (start_cnt - s0 != 1) begin n_fail++; $display("FAIL u_start_pulse: got %0d cycles want 1", start_cnt - s0); end
      n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL u_in1_hold: got %0d changed cycles want 0", bad); end
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL u_pop: resp_valid got %b want 0", resp_valid); end
   endtask

   task automatic test_signed_b2b();
      int acc1, acc2, t1, t2, n;
      logic [W-1:0]  q1, r1;
      logic [TW-1:0] tg1;
      logic          got1, sgn_ok;
      resp_ready = 1'b1;
      send(32'hFFFF_FFF9, 32'd2, 1'b1, 4'd8, acc1);
      sgn_ok = (div_sign === 1'b1);
      req_in1 = 32'd7; req_in2 = 32'hFFFF_FFFE; req_sign = 1'b1; req_tag = 4'd9; req_valid = 1'b1;
      got1 = 1'b0; acc2 = -1; t1 = -1; n = 0; q1 = '0; r1 = '0; tg1 = '0;
      while (acc2 < 0 && n < 100) begin
         if (resp_valid && !got1) begin got1 = 1'b1; t1 = cyc; q1 = resp_quot; r1 = resp_rem; tg1 = resp_tag; end
         if (req_ready) acc2 = cyc;
         @(negedge clk); n++;
      end
      req_valid = 1'b0;
      n_cmp++; if (sgn_ok !== 1'b1) begin n_fail++; $display("FAIL s_div_sign: got %b want 1", div_sign); end
      n_cmp++; if (t1 - acc1 != 19) begin n_fail++; $display("FAIL s1_latency: got %0d want 19", t1 - acc1); end
      n_cmp++; if ({q1, r1, tg1} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'd8}) begin
         n_fail++; $display("FAIL s1_result: got %h %h %h want fffffffd ffffffff 8", q1, r1, tg1); end
      n_cmp++; if (acc2 != t1) begin n_fail++; $display("FAIL s2_issue_cycle: got %0d want %0d", acc2, t1); end
      wait_resp(t2);
      n_cmp++; if (t2 - acc2 != 19) begin n_fail++; $display("FAIL s2_latency_stale_done: got %0d want 19", t2 - acc2); end
      n_cmp++; if ({resp_quot, resp_rem, resp_dbz, resp_tag} !== {32'hFFFF_FFFD, 32'h0000_0001, 1'b0, 4'd9}) begin
         n_fail++; $display("FAIL s2_result: got %h %h %b %h want fffffffd 1 0 9", resp_quot, resp_rem, resp_dbz, resp_tag); end
      @(negedge clk);
   endtask

   task automatic test_dbz();
      int acc, at, s0;
      resp_ready = 1'b1; s0 = start_cnt;
      send(32'h0000_1234, 32'd0, 1'b0, 4'd5, acc);
      wait_resp(at);
      n_cmp++; if (at - acc != 1) begin n_fail++; $display("FAIL dbz_latency: got %0d want 1", at - acc); end
      n_cmp++; if ({resp_quot, resp_rem, resp_dbz, resp_tag} !== {32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 4'd5}) begin
         n_fail++; $display("FAIL dbz_result: got %h %h %b %h want ffffffff 1234 1 5", resp_quot, resp_rem, resp_dbz, resp_tag); end
      repeat (3) @(negedge clk);
      n_cmp++; if (start_cnt != s0) begin n_fail++; $display("FAIL dbz_no_start: got %0d pulses want 0", start_cnt - s0); end
      n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL dbz_pop: resp_valid got %b want 0", resp_valid); end
   endtask

   task automatic test_backpressure();
      int a1, a2, acc3, at;
      resp_ready = 1'b0;
      send(32'd10, 32'd3, 1'b0, 4'd1, a1);
      send(32'd0, 32'd0, 1'b0, 4'd2, a2);
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_ready: got %b want 0", req_ready); end
      repeat (4) @(negedge clk);
      n_cmp++; if ({resp_valid, resp_quot, resp_rem, resp_dbz, resp_tag} !== {1'b1, 32'd3, 32'd1, 1'b0, 4'd1}) begin
         n_fail++; $display("FAIL bp_head0_hold: got %b %h %h %b %h want 1 3 1 0 1", resp_valid, resp_quot, resp_rem, resp_dbz, resp_tag); end
      req_in1 = 32'd9; req_in2 = 32'd9; req_sign = 1'b0; req_tag = 4'd4; req_valid = 1'b1;
      n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_accept_before_pop: got %b want 0", req_ready); end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      n_cmp++; if ({resp_quot, resp_rem, resp_dbz, resp_tag} !== {32'hFFFF_FFFF, 32'd0, 1'b1, 4'd2}) begin
         n_fail++; $display("FAIL bp_head1: got %h %h %b %h want ffffffff 0 1 2", resp_quot, resp_rem, resp_dbz, resp_tag); end
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after_pop: got %b want 1", req_ready); end
      acc3 = cyc;
      @(negedge clk);
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain1: resp_valid got %b want 0", resp_valid); end
      wait_resp(at);
      n_cmp++; if (at - acc3 != 19) begin n_fail++; $display("FAIL bp_op3_latency: got %0d want 19", at - acc3); end
      n_cmp++; if ({resp_quot, resp_rem, resp_dbz, resp_tag} !== {32'd1, 32'd0, 1'b0, 4'd4}) begin
         n_fail++; $display("FAIL bp_head2: got %h %h %b %h want 1 0 0 4", resp_quot, resp_rem, resp_dbz, resp_tag); end
      @(negedge clk);
   endtask

   task automatic test_min_neg1();
      int acc, at;
      resp_ready = 1'b1;
      send(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'd6, acc);
      wait_resp(at);
      n_cmp++; if ({resp_quot, resp_rem, resp_dbz, resp_tag} !== {32'h8000_0000, 32'd0, 1'b0, 4'd6}) begin
         n_fail++; $display("FAIL min_neg1: got %h %h %b %h want 80000000 0 0 6", resp_quot, resp_rem, resp_dbz, resp_tag); end
      @(negedge clk);
   endtask

   task automatic test_reset_midop();
      int acc, at;
      resp_ready = 1'b0;
      send(32'd0, 32'd0, 1'b0, 4'hA, acc);
      send(32'd1000, 32'd3, 1'b0, 4'hB, acc);
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_cmp++; if ({resp_valid, req_ready, div_start} !== 3'b010) begin
         n_fail++; $display("FAIL rm_after_reset: got valid=%b ready=%b start=%b want 0 1 0", resp_valid, req_ready, div_start); end
      n_cmp++; if ({resp_quot, resp_tag} !== '0) begin n_fail++; $display("FAIL rm_resp_cleared: got %h %h want 0", resp_quot, resp_tag); end
      resp_ready = 1'b1;
      repeat (20) @(negedge clk);
      n_cmp++; if ({resp_valid, req_ready} !== 2'b01) begin
         n_fail++; $display("FAIL rm_dropped_op: got valid=%b ready=%b want 0 1", resp_valid, req_ready); end
      send(32'd50, 32'd5, 1'b0, 4'hC, acc);
      wait_resp(at);
      n_cmp++; if (at - acc != 19) begin n_fail++; $display("FAIL rm_fresh_latency: got %0d want 19", at - acc); end
      n_cmp++; if ({resp_quot, resp_rem, resp_dbz, resp_tag} !== {32'd10, 32'd0, 1'b0, 4'hC}) begin
         n_fail++; $display("FAIL rm_fresh_result: got %h %h %b %h want a 0 0 c", resp_quot, resp_rem, resp_dbz, resp_tag); end
      @(negedge clk);
   endtask

   task automatic test_random();
      int acc, at, hold, exp_lat;
      logic [W-1:0]      a, b;
      logic              s;
      logic [TW-1:0]     t;
      logic [2*W-1:0]    qr;
      logic [2*W+TW:0]   exp_h;
      for (int i = 0; i < 40; i++) begin
         a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1)); t = 4'($urandom_range(0, 15));
         case ($urandom_range(0, 7))
            0: b = '0;
            1: b = $urandom_range(1, 15);
            2: begin a = 32'h8000_0000; b = '1; s = 1'b1; end
            3: b = ($urandom >> $urandom_range(0, 31)) | 32'd1;
            default: ;
         endcase
         qr      = ref_div(a, b, s);
         exp_h   = {qr, (b == '0), t};
         exp_lat = (b == '0) ? 1 : 19;
         resp_ready = 1'b0;
         send(a, b, s, t, acc);
         wait_resp(at);
         n_cmp++; if (at - acc != exp_lat) begin n_fail++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, at - acc, exp_lat); end
         hold = $urandom_range(0, 3);
         repeat (hold) @(negedge clk);
         n_cmp++; if ({resp_quot, resp_rem, resp_dbz, resp_tag} !== exp_h) begin
            n_fail++; $display("FAIL rnd%0d_result: a=%h b=%h s=%b got %h %h %b %h want %h", i, a, b, s, resp_quot, resp_rem, resp_dbz, resp_tag, exp_h); end
         resp_ready = 1'b1;
         @(negedge clk);
         resp_ready = 1'b0;
         n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd%0d_pop: resp_valid got %b want 0", i, resp_valid); end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_in1 = '0; req_in2 = '0; req_sign = 1'b0; req_tag = '0;
      resp_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_unsigned();
      test_signed_b2b();
      test_dbz();
      test_backpressure();
      test_min_neg1();
      test_reset_midop();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
